exec_unit: RTL and testbench
============================

# exec_unit

Parametrised execute stage for the 3-stage pipeline. It accepts one decoded operation per issue handshake, computes a registered ALU result, and signals completion for GPR write-back. Single-cycle ops complete in one clock. MUL/MULHU run either as an iterative shift-add over DATA_WIDTH cycles or as a single cycle, chosen by parameter. It sits between decode/regfile read and write-back, replacing the fixed-width execute block.

## Interface
- DATA_WIDTH, 32: operand/result width; power of two, ≥8.
- ADDR_WIDTH, 32: PC/address width.
- MUL_ITERATIVE, 1: 1 = radix-2 iterative multiplier (DATA_WIDTH cycles); 0 = single-cycle multiplier.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  freezes all state (counter, registers, outputs) while high.
- issue_valid  in  1  decode presents an operation.
- issue_ready  out  1  unit can accept; = (state==IDLE) && !stall.
- alu_fns_sel  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low half), 11 MULHU (high half, unsigned); 12–15 illegal.
- pc_exe  in  ADDR_WIDTH  PC of the issued instruction.
- regA, regB  in  DATA_WIDTH  source operands.
- alu_result  out  DATA_WIDTH  registered result.
- carry_out  out  1  ADD: carry; SUB: carry of A+~B+1 (1 = no borrow); else 0.
- address  out  ADDR_WIDTH  pc_exe captured at accept, held until next accept.
- instr_complete  out  1  one-cycle pulse; alu_result/carry_out/address valid for write-back.
- illegal_op  out  1  pulses with instr_complete for opcodes 12–15.
- busy  out  1  high while in MUL state.

## Operation
- Accept = issue_valid && issue_ready at a rising edge. Operands, opcode and pc_exe are sampled only at accept.
- States: IDLE, MUL. Reset → IDLE.
- IDLE, accept, non-MUL opcode (or MUL_ITERATIVE=0): compute and register result; pulse instr_complete next cycle; stay IDLE.
- IDLE, accept, opcode 10/11, MUL_ITERATIVE=1: load multiplicand, multiplier and a 2·DATA_WIDTH accumulator; count = DATA_WIDTH; → MUL.
- MUL: each unstalled cycle adds the shifted multiplicand when the multiplier LSB is 1, shifts, decrements count. At count reaching 0: write low half (MUL) or high half (MULHU) to alu_result, pulse instr_complete, → IDLE.
- Shifts use regB[log2(DATA_WIDTH)-1:0]. SRA is arithmetic. SLT is signed; SLTU is unsigned; result is zero-extended 0/1.
- Sums and products are computed at full width and truncated to DATA_WIDTH. ADD/SUB wrap modulo 2^DATA_WIDTH.
- Illegal opcode: alu_result = 0, carry_out = 0, illegal_op and instr_complete pulse.
- Stall: no accept, no counter progress, all outputs hold. Any instr_complete already high is held high for the stalled cycles. Write-back must qualify it with !stall.
- Reset values (asynchronous, immediate): alu_result 0, carry_out 0, address 0, instr_complete 0, illegal_op 0, busy 0, state IDLE. Reset during MUL aborts the operation with no completion.

## Timing
- Single-cycle ops: accept at edge N → instr_complete high between edge N and edge N+1. Back-to-back accepts give one completion per cycle.
- Iterative MUL: accept at edge N → instr_complete high after edge N+DATA_WIDTH, for one cycle, plus any stalled cycles inserted. issue_ready is low from edge N until the completion edge. A new op can be accepted on the completion edge's following cycle.
- MUL_ITERATIVE=0: MUL/MULHU have 1-cycle latency, same as ALU ops.
- instr_complete is low on any cycle with no completion. It never stays high across two consecutive unstalled cycles unless two ops completed.

## Test plan
- Reset/idle: assert reset_n=0 mid-cycle → all outputs 0 immediately; release → issue_ready=1, instr_complete=0.
- ALU ops (DATA_WIDTH=32), back-to-back:
  - ADD 0xFFFFFFFF+1 → result 0, carry_out 1.
  - SUB 5−7 → 0xFFFFFFFE, carry_out 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - Each op completes one cycle after accept.
- Iterative MUL: 0x0001_0000 × 0x0001_0000, MUL → 0 and MULHU → 1. 0xFFFFFFFF×0xFFFFFFFF MULHU → 0xFFFFFFFE. Complete exactly 32 cycles after accept; issue_ready low throughout.
- Stall: hold stall=1 for 5 cycles mid-MUL → completion delayed by exactly 5 cycles, result unchanged. Stall during an instr_complete pulse → pulse and result held.
- Reset mid-MUL at cycle 10 → no instr_complete, outputs 0; next ADD 3+4 → 7 after one cycle.
- Illegal opcode 13 → alu_result 0, illegal_op and instr_complete pulse together. Repeat the ALU and MUL checks with MUL_ITERATIVE=0 and with DATA_WIDTH=16 → MUL has 1-cycle latency; 16-bit wrap/shift values are correct.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: registered single-cycle ALU plus MUL/MULHU, either as a radix-2
// shift-add sequence over DATA_WIDTH cycles or as a one-cycle multiplier.
module exec_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MUL_ITERATIVE = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [3:0]            alu_fns_sel,
  input  logic [ADDR_WIDTH-1:0] pc_exe,
  input  logic [DATA_WIDTH-1:0] regA,
  input  logic [DATA_WIDTH-1:0] regB,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  carry_out,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  instr_complete,
  output logic                  illegal_op,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6, OP_SRA = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL = 4'd10, OP_MULHU = 4'd11
  } op_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t state, state_next;

  logic                    accept;
  logic                    is_mul_op;
  logic                    start_mul;
  logic                    mul_last;
  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH:0]     sum_add;
  logic [DATA_WIDTH:0]     sum_sub;
  logic [2*DATA_WIDTH-1:0] product_full;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_carry;
  logic                    alu_illegal;

  logic [2*DATA_WIDTH-1:0] mul_acc;
  logic [2*DATA_WIDTH-1:0] mul_acc_next;
  logic [DATA_WIDTH:0]     mul_hi_sum;
  logic [DATA_WIDTH-1:0]   mul_mcand;
  logic                    mul_high;
  logic [CW-1:0]           count;

  assign accept    = issue_valid && issue_ready;
  assign is_mul_op = (alu_fns_sel == OP_MUL) || (alu_fns_sel == OP_MULHU);
  assign start_mul = accept && is_mul_op && (MUL_ITERATIVE != 0);
  assign mul_last  = (state == ST_MUL) && (count == CW'(1));

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: assign a default first so no path through the block infers a latch.
    state_next = state;
    if (!stall) begin
      case (state)
        ST_IDLE: if (start_mul) state_next = ST_MUL;
        ST_MUL:  if (mul_last)  state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_ready = (state == ST_IDLE) && !stall;
    busy        = (state == ST_MUL);
  end

  // ---------------- Single-cycle datapath ----------------
  if (MUL_ITERATIVE == 0) begin : g_comb_mul
    assign product_full = {{DATA_WIDTH{1'b0}}, regA} * {{DATA_WIDTH{1'b0}}, regB};
  end else begin : g_iter_mul
    assign product_full = '0;
  end

  assign shamt   = regB[SHW-1:0];
  assign sum_add = {1'b0, regA} + {1'b0, regB};
  // Subtract as A + ~B + 1 so the carry reads as "no borrow".
  assign sum_sub = {1'b0, regA} + {1'b0, ~regB} + {{DATA_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (alu_fns_sel)
      OP_ADD:   begin alu_res = sum_add[DATA_WIDTH-1:0]; alu_carry = sum_add[DATA_WIDTH]; end
      OP_SUB:   begin alu_res = sum_sub[DATA_WIDTH-1:0]; alu_carry = sum_sub[DATA_WIDTH]; end
      OP_AND:   alu_res = regA & regB;
      OP_OR:    alu_res = regA | regB;
      OP_XOR:   alu_res = regA ^ regB;
      OP_SLL:   alu_res = regA << shamt;
      OP_SRL:   alu_res = regA >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(regA) >>> shamt);
      OP_SLT:   alu_res = DATA_WIDTH'($signed(regA) < $signed(regB));
      OP_SLTU:  alu_res = DATA_WIDTH'(regA < regB);
      OP_MUL:   alu_res = product_full[DATA_WIDTH-1:0];
      OP_MULHU: alu_res = product_full[2*DATA_WIDTH-1:DATA_WIDTH];
      default:  alu_illegal = 1'b1;
    endcase
  end

  // ---------------- Iterative multiplier step ----------------
  // Upper half accumulates the multiplicand while the lower half shifts the
  // multiplier out LSB-first; after DATA_WIDTH steps mul_acc holds the product.
  assign mul_hi_sum   = mul_acc[0] ? ({1'b0, mul_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mul_mcand})
                                   : {1'b0, mul_acc[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign mul_acc_next = {mul_hi_sum, mul_acc[DATA_WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result     <= '0;
      carry_out      <= 1'b0;
      address        <= '0;
      instr_complete <= 1'b0;
      illegal_op     <= 1'b0;
      mul_acc        <= '0;
      mul_mcand      <= '0;
      mul_high       <= 1'b0;
      count          <= '0;
    end else if (!stall) begin
      instr_complete <= 1'b0;
      illegal_op     <= 1'b0;
      if (accept) begin
        address <= pc_exe;
        if (start_mul) begin
          mul_acc   <= {{DATA_WIDTH{1'b0}}, regB};
          mul_mcand <= regA;
          mul_high  <= (alu_fns_sel == OP_MULHU);
          count     <= CW'(DATA_WIDTH);
        end else begin
          alu_result     <= alu_res;
          carry_out      <= alu_carry;
          illegal_op     <= alu_illegal;
          instr_complete <= 1'b1;
        end
      end else if (state == ST_MUL) begin
        mul_acc <= mul_acc_next;
        count   <= count - CW'(1);
        if (mul_last) begin
          alu_result     <= mul_high ? mul_acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : mul_acc_next[DATA_WIDTH-1:0];
          carry_out      <= 1'b0;
          instr_complete <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: a 32-bit iterative instance, a 32-bit
// single-cycle-multiply instance and a 16-bit single-cycle instance.
module tb_exec_unit;

  typedef struct packed {
    logic        ill;
    logic        carry;
    logic [31:0] res;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic stall   = 1'b0;

  // Instance A: DATA_WIDTH 32, iterative multiply.
  logic        a_valid = 1'b0, a_ready;
  logic [3:0]  a_sel = '0;
  logic [31:0] a_pc = '0, a_ra = '0, a_rb = '0;
  logic [31:0] a_result, a_address;
  logic        a_carry, a_complete, a_illegal, a_busy;

  // Shared stimulus for instances B (32-bit) and C (16-bit), both single-cycle multiply.
  logic        s_valid = 1'b0;
  logic [3:0]  s_sel = '0;
  logic [31:0] s_pc = '0, s_ra = '0, s_rb = '0;
  logic [31:0] b_result, b_address, c_address;
  logic [15:0] c_result;
  logic        b_ready, b_carry, b_complete, b_illegal, b_busy;
  logic        c_ready, c_carry, c_complete, c_illegal, c_busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  exec_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MUL_ITERATIVE(1)) dut_iter (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .issue_valid(a_valid), .issue_ready(a_ready), .alu_fns_sel(a_sel),
    .pc_exe(a_pc), .regA(a_ra), .regB(a_rb),
    .alu_result(a_result), .carry_out(a_carry), .address(a_address),
    .instr_complete(a_complete), .illegal_op(a_illegal), .busy(a_busy)
  );

  exec_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MUL_ITERATIVE(0)) dut_comb (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .issue_valid(s_valid), .issue_ready(b_ready), .alu_fns_sel(s_sel),
    .pc_exe(s_pc), .regA(s_ra), .regB(s_rb),
    .alu_result(b_result), .carry_out(b_carry), .address(b_address),
    .instr_complete(b_complete), .illegal_op(b_illegal), .busy(b_busy)
  );

  exec_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .MUL_ITERATIVE(0)) dut_w16 (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .issue_valid(s_valid), .issue_ready(c_ready), .alu_fns_sel(s_sel),
    .pc_exe(s_pc), .regA(s_ra[15:0]), .regB(s_rb[15:0]),
    .alu_result(c_result), .carry_out(c_carry), .address(c_address),
    .instr_complete(c_complete), .illegal_op(c_illegal), .busy(c_busy)
  );

  // Reference model: plain 64-bit arithmetic masked to width w.
  function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int w);
    logic [63:0] mask, a, b, full;
    longint      sa, sb;
    int          sh;
    exp_t        e;
    e    = '0;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'd0, a_in} & mask;
    b    = {32'd0, b_in} & mask;
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    sh   = int'(b % 64'(w));
    case (sel)
      4'd0:  begin full = a + b; e.res = 32'(full & mask); e.carry = full[w]; end
      4'd1:  begin full = a + (~b & mask) + 64'd1; e.res = 32'(full & mask); e.carry = full[w]; end
      4'd2:  e.res = 32'(a & b);
      4'd3:  e.res = 32'(a | b);
      4'd4:  e.res = 32'(a ^ b);
      4'd5:  e.res = 32'((a << sh) & mask);
      4'd6:  e.res = 32'(a >> sh);
      4'd7:  e.res = 32'(64'(sa >>> sh) & mask);
      4'd8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin full = a * b; e.res = 32'(full & mask); end
      4'd11: begin full = a * b; e.res = 32'(full >> w); end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({a_result, a_carry, a_address, a_complete, a_illegal, a_busy,
         b_result, b_carry, b_address, b_complete, b_illegal, b_busy,
         c_result, c_carry, c_address, c_complete, c_illegal, c_busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h/%h b=%h/%h c=%h/%h, want all zero",
               a_result, a_address, b_result, b_address, c_result, c_address);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    total++;
    if ({a_ready, b_ready, c_ready, a_complete, b_complete, c_complete} !== 6'b111000) begin
      bad++;
      $display("FAIL reset_release: got ready/complete=%b want 111000",
               {a_ready, b_ready, c_ready, a_complete, b_complete, c_complete});
    end
    // Make outputs non-zero, then assert reset mid-cycle.
    a_sel = 4'd0; a_ra = 32'd3; a_rb = 32'd4; a_pc = 32'h40; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    total++;
    if ({a_complete, a_result, a_address} !== {1'b1, 32'd7, 32'h40}) begin
      bad++;
      $display("FAIL reset_pre_add: got c=%b r=%h a=%h want 1/7/40", a_complete, a_result, a_address);
    end
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({a_result, a_carry, a_address, a_complete, a_illegal, a_busy} !== '0) begin
      bad++;
      $display("FAIL reset_midcycle: got r=%h a=%h c=%b want zero", a_result, a_address, a_complete);
    end
    #1 reset_n = 1'b1;
    tick();
    total++;
    if ({a_ready, a_complete} !== 2'b10) begin
      bad++;
      $display("FAIL reset_midcycle_release: got ready/complete=%b want 10", {a_ready, a_complete});
    end
  endtask

  task automatic test_alu_directed();
    logic [3:0]  d_sel [9] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd1, 4'd4};
    logic [31:0] d_a   [9] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd1, 32'h8000_0000, 32'd7, 32'h0000_F0F0};
    logic [31:0] d_b   [9] = '{32'd1, 32'd7, 32'd4, 32'd1, 32'd1, 32'd31, 32'd31, 32'd5, 32'h0000_FF00};
    logic [31:0] d_res [9] = '{32'd0, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0,
                               32'h8000_0000, 32'd1, 32'd2, 32'h0000_0FF0};
    logic        d_cy  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      a_sel = d_sel[i]; a_ra = d_a[i]; a_rb = d_b[i]; a_pc = 32'h1000 + 32'(4 * i);
      a_valid = 1'b1;
      tick();
      total++;
      if ({a_complete, a_illegal, a_carry, a_result, a_address} !==
          {1'b1, 1'b0, d_cy[i], d_res[i], 32'h1000 + 32'(4 * i)}) begin
        bad++;
        $display("FAIL alu_directed[%0d]: got c=%b cy=%b r=%h pc=%h want c=1 cy=%b r=%h",
                 i, a_complete, a_carry, a_result, a_address, d_cy[i], d_res[i]);
      end
    end
    a_valid = 1'b0;
    tick();
    total++;
    if (a_complete !== 1'b0) begin
      bad++;
      $display("FAIL alu_directed_idle: got complete=%b want 0", a_complete);
    end
  endtask

  task automatic test_alu_random();
    exp_t ea, eb, ec;
    for (int i = 0; i < 60; i++) begin
      do a_sel = 4'($urandom_range(15)); while (a_sel == 4'd10 || a_sel == 4'd11);
      a_ra = rand_operand(); a_rb = rand_operand(); a_pc = $urandom;
      s_sel = 4'($urandom_range(15));
      s_ra = rand_operand(); s_rb = rand_operand(); s_pc = $urandom;
      a_valid = 1'b1; s_valid = 1'b1;
      ea = model(a_sel, a_ra, a_rb, 32);
      eb = model(s_sel, s_ra, s_rb, 32);
      ec = model(s_sel, s_ra, s_rb, 16);
      tick();
      total++;
      if ({a_complete, a_illegal, a_carry, a_result, a_address} !== {1'b1, ea.ill, ea.carry, ea.res, a_pc}) begin
        bad++;
        $display("FAIL alu_rand_w32iter[%0d] op=%0d: got c=%b il=%b cy=%b r=%h want il=%b cy=%b r=%h",
                 i, a_sel, a_complete, a_illegal, a_carry, a_result, ea.ill, ea.carry, ea.res);
      end
      total++;
      if ({b_complete, b_illegal, b_carry, b_result, b_address} !== {1'b1, eb.ill, eb.carry, eb.res, s_pc}) begin
        bad++;
        $display("FAIL alu_rand_w32[%0d] op=%0d: got c=%b il=%b cy=%b r=%h want il=%b cy=%b r=%h",
                 i, s_sel, b_complete, b_illegal, b_carry, b_result, eb.ill, eb.carry, eb.res);
      end
      total++;
      if ({c_complete, c_illegal, c_carry, c_result, c_address} !== {1'b1, ec.ill, ec.carry, ec.res[15:0], s_pc}) begin
        bad++;
        $display("FAIL alu_rand_w16[%0d] op=%0d: got c=%b il=%b cy=%b r=%h want il=%b cy=%b r=%h",
                 i, s_sel, c_complete, c_illegal, c_carry, c_result, ec.ill, ec.carry, ec.res[15:0]);
      end
    end
    a_valid = 1'b0; s_valid = 1'b0;
    tick();
    total++;
    if ({a_complete, b_complete, c_complete} !== 3'b000) begin
      bad++;
      $display("FAIL alu_rand_idle: got completes=%b want 000", {a_complete, b_complete, c_complete});
    end
  endtask

  // Single-cycle multiply and 16-bit wrap/shift corner cases.
  task automatic test_bc_directed();
    logic [3:0]  t_sel [10] = '{4'd10, 4'd11, 4'd11, 4'd0, 4'd7, 4'd1, 4'd10, 4'd11, 4'd5, 4'd8};
    logic [31:0] t_a   [10] = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_8000,
                                32'd5, 32'h100, 32'h100, 32'd1, 32'h0000_FFFF};
    logic [31:0] t_b   [10] = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd1, 32'd4,
                                32'd7, 32'h100, 32'h100, 32'd19, 32'd1};
    logic [31:0] t_rb  [10] = '{32'd0, 32'd1, 32'hFFFF_FFFE, 32'h0001_0000, 32'h0000_0800,
                                32'hFFFF_FFFE, 32'h0001_0000, 32'd0, 32'h0008_0000, 32'd0};
    logic [15:0] t_rc  [10] = '{16'd0, 16'd0, 16'hFFFE, 16'd0, 16'hF800, 16'hFFFE, 16'd0, 16'd1, 16'd8, 16'd1};
    logic        t_cc  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      s_sel = t_sel[i]; s_ra = t_a[i]; s_rb = t_b[i]; s_pc = 32'h2000 + 32'(i);
      s_valid = 1'b1;
      tick();
      total++;
      if ({b_complete, b_illegal, b_carry, b_result} !== {1'b1, 1'b0, 1'b0, t_rb[i]}) begin
        bad++;
        $display("FAIL bc_w32[%0d]: got c=%b cy=%b r=%h want c=1 cy=0 r=%h",
                 i, b_complete, b_carry, b_result, t_rb[i]);
      end
      total++;
      if ({c_complete, c_illegal, c_carry, c_result} !== {1'b1, 1'b0, t_cc[i], t_rc[i]}) begin
        bad++;
        $display("FAIL bc_w16[%0d]: got c=%b cy=%b r=%h want c=1 cy=%b r=%h",
                 i, c_complete, c_carry, c_result, t_cc[i], t_rc[i]);
      end
    end
    s_valid = 1'b0;
    tick();
  endtask

  // Iterative multiply with optional stall window starting stall_at cycles after accept.
  task automatic mul_op(input logic [3:0] sel, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] exp_val, input int stall_at, input int stall_len);
    int          k;
    int          hold_bad;
    logic        done;
    logic [31:0] pc;
    pc = $urandom;
    a_sel = sel; a_ra = ra; a_rb = rb; a_pc = pc; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_ra = $urandom; a_rb = $urandom; a_pc = $urandom;
    total++;
    if ({a_busy, a_ready, a_complete} !== 3'b100) begin
      bad++;
      $display("FAIL mul_start: got busy/ready/complete=%b want 100", {a_busy, a_ready, a_complete});
    end
    k = 0; hold_bad = 0; done = 1'b0;
    while (!done && k < 100) begin
      if (stall_len > 0 && k == stall_at) stall = 1'b1;
      if (stall_len > 0 && k == stall_at + stall_len) stall = 1'b0;
      tick();
      k++;
      if (a_complete === 1'b1) done = 1'b1;
      else if (a_ready !== 1'b0 || a_busy !== 1'b1) hold_bad++;
    end
    stall = 1'b0;
    total++;
    if (!done || k != 32 + stall_len) begin
      bad++;
      $display("FAIL mul_latency: got done=%b after %0d cycles want %0d", done, k, 32 + stall_len);
    end
    total++;
    if ({a_illegal, a_carry, a_result, a_address} !== {1'b0, 1'b0, exp_val, pc}) begin
      bad++;
      $display("FAIL mul_result op=%0d: got r=%h pc=%h want r=%h pc=%h", sel, a_result, a_address, exp_val, pc);
    end
    total++;
    if ({a_ready, a_busy} !== 2'b10) begin
      bad++;
      $display("FAIL mul_done_state: got ready/busy=%b want 10", {a_ready, a_busy});
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("FAIL mul_ready_low: got %0d cycles with ready high or busy low want 0", hold_bad);
    end
    tick();
    total++;
    if (a_complete !== 1'b0) begin
      bad++;
      $display("FAIL mul_single_pulse: got complete=%b want 0", a_complete);
    end
  endtask

  task automatic test_mul_iter();
    logic [31:0] ra, rb;
    mul_op(4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0, -1, 0);
    mul_op(4'd11, 32'h0001_0000, 32'h0001_0000, 32'd1, -1, 0);
    mul_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1, 0);
    for (int i = 0; i < 4; i++) begin
      ra = rand_operand(); rb = rand_operand();
      mul_op(4'(10 + (i % 2)), ra, rb, model(4'(10 + (i % 2)), ra, rb, 32).res, -1, 0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ra, rb, held;
    ra = $urandom; rb = $urandom;
    mul_op(4'd11, ra, rb, model(4'd11, ra, rb, 32).res, 10, 5);
    // Stall landing on a completion pulse; a pending issue must wait.
    a_sel = 4'd4; a_ra = 32'h1234_5678; a_rb = 32'h0F0F_0F0F; a_pc = 32'h300; a_valid = 1'b1;
    tick();
    held = a_result;
    stall = 1'b1;
    a_sel = 4'd0; a_ra = 32'd10; a_rb = 32'd20; a_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({a_complete, a_result, a_address, a_ready} !== {1'b1, 32'h1D3B_5977, 32'h300, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got c=%b r=%h pc=%h rdy=%b want 1/1d3b5977/300/0",
                 i, a_complete, a_result, a_address, a_ready);
      end
    end
    stall = 1'b0;
    tick();
    a_valid = 1'b0;
    total++;
    if ({a_complete, a_result, a_address} !== {1'b1, 32'd30, 32'h304}) begin
      bad++;
      $display("FAIL stall_release: got c=%b r=%h pc=%h (held %h) want 1/1e/304", a_complete, a_result, a_address, held);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    a_sel = 4'd10; a_ra = 32'hFFFF_FFFF; a_rb = 32'd3; a_valid = 1'b1; a_pc = 32'h500;
    tick();
    a_valid = 1'b0;
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({a_result, a_carry, a_address, a_complete, a_illegal, a_busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_mul: got r=%h pc=%h busy=%b want zero", a_result, a_address, a_busy);
    end
    #1 reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (a_complete !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_mul_no_complete: got %0d completions want 0", seen);
    end
    a_sel = 4'd0; a_ra = 32'd3; a_rb = 32'd4; a_pc = 32'h504; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    total++;
    if ({a_complete, a_result, a_carry} !== {1'b1, 32'd7, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_mul_add: got c=%b r=%h want 1/7", a_complete, a_result);
    end
    tick();
  endtask

  task automatic test_illegal();
    a_sel = 4'd0; a_ra = 32'd1; a_rb = 32'd2; a_valid = 1'b1;
    s_sel = 4'd0; s_ra = 32'hFFFF; s_rb = 32'd1; s_valid = 1'b1;
    tick();
    a_sel = 4'd13; a_ra = 32'd5; a_rb = 32'd6;
    s_sel = 4'd13;
    tick();
    a_valid = 1'b0; s_valid = 1'b0;
    total++;
    if ({a_complete, a_illegal, a_carry, a_result} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL illegal_w32iter: got c=%b il=%b cy=%b r=%h want 1/1/0/0", a_complete, a_illegal, a_carry, a_result);
    end
    total++;
    if ({b_complete, b_illegal, b_carry, b_result, c_complete, c_illegal, c_carry, c_result} !==
        {1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL illegal_bc: got b=%b/%b/%h c=%b/%b/%h want 1/1/0", b_complete, b_illegal, b_result,
               c_complete, c_illegal, c_result);
    end
    tick();
    total++;
    if ({a_complete, a_illegal, b_complete, b_illegal, c_complete, c_illegal} !== 6'b000000) begin
      bad++;
      $display("FAIL illegal_pulse_end: got %b want 000000",
               {a_complete, a_illegal, b_complete, b_illegal, c_complete, c_illegal});
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_bc_directed();
    test_mul_iter();
    test_stall();
    test_reset_mid_mul();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
